// File: rtl/clock_disp_pkg.sv
// Shared display constants: active-low 7-segment glyphs (bit0 = a), digit indices and the pin payload.
package clock_disp_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  localparam logic [2:0] DIG_SEC_ONES  = 3'd0;
  localparam logic [2:0] DIG_SEC_TENS  = 3'd1;
  localparam logic [2:0] DIG_MIN_ONES  = 3'd2;
  localparam logic [2:0] DIG_MIN_TENS  = 3'd3;
  localparam logic [2:0] DIG_HOUR_ONES = 3'd4;
  localparam logic [2:0] DIG_HOUR_TENS = 3'd5;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

  typedef struct packed {
    logic [6:0]            seg_n;
    logic                  dp_n;
    logic [NUM_DIGITS-1:0] an_n;
  } disp_out_t;

  function automatic logic [6:0] seg_glyph(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_glyph = SEG_0;
      4'd1:    seg_glyph = SEG_1;
      4'd2:    seg_glyph = SEG_2;
      4'd3:    seg_glyph = SEG_3;
      4'd4:    seg_glyph = SEG_4;
      4'd5:    seg_glyph = SEG_5;
      4'd6:    seg_glyph = SEG_6;
      4'd7:    seg_glyph = SEG_7;
      4'd8:    seg_glyph = SEG_8;
      4'd9:    seg_glyph = SEG_9;
      default: seg_glyph = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_99.sv
// Combinational split of a 0..99 binary value into BCD tens/ones; flags values above 99.
module bin2bcd_99 (
  input  logic [7:0] value,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       invalid
);

  always_comb begin
    invalid = (value > 8'd99);
    tens    = 4'(value / 8'd10);
    ones    = 4'(value % 8'd10);
    if (invalid) begin
      tens = 4'd0;
      ones = 4'd0;
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Six-digit multiplexed HH MM SS driver with frame snapshots and alarm blink.
// Optional: SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks a zero hour-tens digit.
module seven_seg_scanner
  import clock_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned ALARM_FRAMES = 2000,
  parameter int unsigned BLINK_SHIFT  = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] display_hour,
  input  logic [7:0] display_min,
  input  logic [7:0] display_sec,
  input  logic       is_pm,
  input  logic       alarm_sound,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] an_n
);

  localparam int unsigned CNT_W   = $clog2(SCAN_DIV);
  localparam int unsigned HOLD_W  = $clog2(ALARM_FRAMES + 1);
  localparam int unsigned FRAME_W = 16;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [7:0]         snap_hour_q, snap_hour_d;
  logic [7:0]         snap_min_q, snap_min_d;
  logic [7:0]         snap_sec_q, snap_sec_d;
  logic               snap_pm_q, snap_pm_d;
  disp_out_t          out_q, out_d;

  logic       tick_c, wrap_c, bcd_bad_c;
  logic [7:0] field_c;
  logic [3:0] tens_c, ones_c;

  // Field feeding the shared converter for the slot about to be shown.
  always_comb begin
    case (idx_q)
      DIG_SEC_ONES, DIG_SEC_TENS: field_c = snap_sec_q;
      DIG_MIN_ONES, DIG_MIN_TENS: field_c = snap_min_q;
      default:                    field_c = snap_hour_q;
    endcase
  end

  bin2bcd_99 u_bcd (
    .value   (field_c),
    .tens    (tens_c),
    .ones    (ones_c),
    .invalid (bcd_bad_c)
  );

  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    frame_d     = frame_q;
    hold_d      = hold_q;
    snap_hour_d = snap_hour_q;
    snap_min_d  = snap_min_q;
    snap_sec_d  = snap_sec_q;
    snap_pm_d   = snap_pm_q;
    out_d       = out_q;

    tick_c = (cnt_q == CNT_W'(SCAN_DIV - 1));
    wrap_c = tick_c && (idx_q == DIG_HOUR_TENS);

    cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);

    // Pins take the current slot on the tick; odd indices are tens digits.
    if (tick_c) begin
      out_d.seg_n = bcd_bad_c ? SEG_DASH : seg_glyph(idx_q[0] ? tens_c : ones_c);
      out_d.dp_n  = ~((idx_q == DIG_SEC_ONES) && snap_pm_q);
      out_d.an_n  = ~(NUM_DIGITS'(1) << idx_q);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      if ((idx_q == DIG_HOUR_TENS) && !bcd_bad_c && (tens_c == 4'd0)) begin
        out_d.seg_n = SEG_BLANK;
        out_d.an_n  = AN_OFF;
      end
`endif
      if ((hold_q != '0) && frame_q[BLINK_SHIFT]) begin
        out_d.an_n = AN_OFF;
      end
      idx_d = idx_q + 3'd1;
    end

    // Snapshot on the wrap so the last slot of a frame still uses the old values.
    if (wrap_c) begin
      idx_d       = DIG_SEC_ONES;
      frame_d     = frame_q + FRAME_W'(1);
      snap_hour_d = display_hour;
      snap_min_d  = display_min;
      snap_sec_d  = display_sec;
      snap_pm_d   = is_pm;
    end

    if (alarm_sound) begin
      hold_d = HOLD_W'(ALARM_FRAMES);
    end else if (wrap_c && (hold_q != '0)) begin
      hold_d = hold_q - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      idx_q       <= DIG_SEC_ONES;
      frame_q     <= '0;
      hold_q      <= '0;
      snap_hour_q <= '0;
      snap_min_q  <= '0;
      snap_sec_q  <= '0;
      snap_pm_q   <= 1'b0;
      out_q       <= '{seg_n: SEG_BLANK, dp_n: 1'b1, an_n: AN_OFF};
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      hold_q      <= hold_d;
      snap_hour_q <= snap_hour_d;
      snap_min_q  <= snap_min_d;
      snap_sec_q  <= snap_sec_d;
      snap_pm_q   <= snap_pm_d;
      out_q       <= out_d;
    end
  end

  assign seg_n = out_q.seg_n;
  assign dp_n  = out_q.dp_n;
  assign an_n  = out_q.an_n;

endmodule
